// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes LEGv8 LDUR/STUR/CBZ/ADDI/SUBI requests into 32-bit instruction
//   words and attaches a word address from a wrapping counter. The output is a
//   single registered stage with a valid/ready handshake. Requests that use an
//   illegal op, or whose immediate does not fit its field, emit no word. They
//   raise a one-cycle err pulse and bump a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   encode request present
//   in_ready   encoder can accept a request this cycle
//   op         0 LDUR, 1 STUR, 2 CBZ, 3 ADDI, 4 SUBI; 5-7 illegal
//   rt         Rt (LDUR/STUR/CBZ) or Rd (ADDI/SUBI)
//   rn         Rn (ignored for CBZ)
//   imm        64-bit sign-extended immediate
//   out_valid  instr/addr hold an encoded word
//   out_ready  downstream accepts the word
//   instr      encoded instruction
//   addr       word address for instr
//   err        one-cycle pulse after a rejected request
//   err_count  saturating count of rejected requests
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [4:0]        rt,
  input  logic [4:0]        rn,
  input  logic [63:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_CBZ  = 3'd2,
    OP_ADDI = 3'd3,
    OP_SUBI = 3'd4
  } op_e;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;

  op_e               opc;
  logic              accept;
  logic              drain;
  logic              legal;
  logic [31:0]       enc;
  logic [ADDR_W-1:0] cnt;

  // Signed range checks: the bits above the field's sign bit must all copy it.
  logic fits_d9;
  logic fits_d19;
  logic fits_u12;

  assign opc      = op_e'(op);
  assign fits_d9  = (&imm[63:8])  | ~(|imm[63:8]);
  assign fits_d19 = (&imm[63:18]) | ~(|imm[63:18]);
  assign fits_u12 = ~(|imm[63:12]);

  // Single output register: it may drain and refill in the same cycle.
  assign in_ready = ~reset & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    enc   = '0;
    legal = 1'b0;
    case (opc)
      OP_LDUR: begin
        enc   = {OPC_LDUR, imm[8:0], 2'b00, rn, rt};
        legal = fits_d9;
      end
      OP_STUR: begin
        enc   = {OPC_STUR, imm[8:0], 2'b00, rn, rt};
        legal = fits_d9;
      end
      OP_CBZ: begin
        enc   = {OPC_CBZ, imm[18:0], rt};
        legal = fits_d19;
      end
      OP_ADDI: begin
        enc   = {OPC_ADDI, imm[11:0], rn, rt};
        legal = fits_u12;
      end
      OP_SUBI: begin
        enc   = {OPC_SUBI, imm[11:0], rn, rt};
        legal = fits_u12;
      end
      default: begin
        enc   = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr     <= '0;
      addr      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (drain) begin
        out_valid <= 1'b0;
      end
      // An accept only happens when the register is empty or draining, so a
      // rejected request can never overwrite a held word.
      if (accept) begin
        if (legal) begin
          out_valid <= 1'b1;
          instr     <= enc;
          addr      <= cnt;
          cnt       <= cnt + ADDR_W'(1);
        end else begin
          err <= 1'b1;
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [4:0]    rt;
  logic [4:0]    rn;
  logic [63:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr;
  logic [AW-1:0] addr;
  logic          err;
  logic [7:0]    err_count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rt(rt), .rn(rn), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .err(err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] instr;
    logic [AW-1:0] addr;
    int          errc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int m_addr = 0;   // model address counter (free running int)
  int m_errc = 0;   // model error count

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: at %0t", name, $time);
  endtask

  // Reference model: builds the word from field positions with arithmetic.
  function automatic void model(input logic [2:0] o, input logic [4:0] t, input logic [4:0] n,
                                input logic [63:0] im, output bit ok, output logic [31:0] w);
    longint s;
    bit [63:0] u;
    bit [63:0] r;
    s  = $signed(im);
    u  = im;
    ok = 1'b0;
    r  = 0;
    case (o)
      3'd0, 3'd1: begin
        ok = (s >= -256) && (s <= 255);
        r  = ((o == 3'd0 ? 64'h7C2 : 64'h7C0) << 21) | ((u & 64'h1FF) << 12) | (64'(n) << 5) | 64'(t);
      end
      3'd2: begin
        ok = (s >= -(64'sd1 <<< 18)) && (s < (64'sd1 <<< 18));
        r  = (64'hB4 << 24) | ((u & 64'h7FFFF) << 5) | 64'(t);
      end
      3'd3, 3'd4: begin
        ok = (u < 64'd4096);
        r  = ((o == 3'd3 ? 64'h244 : 64'h344) << 22) | ((u & 64'hFFF) << 10) | (64'(n) << 5) | 64'(t);
      end
      default: ok = 1'b0;
    endcase
    w = r[31:0];
  endfunction

  function automatic void push_exp(input bit ok, input logic [31:0] w);
    exp_t e;
    e.is_err = !ok;
    e.instr  = w;
    e.addr   = AW'(m_addr % (1 << AW));
    e.errc   = 0;
    if (ok) begin
      m_addr++;
    end else begin
      if (m_errc < 255) m_errc++;
      e.errc = m_errc;
    end
    q.push_back(e);
  endfunction

  // Drive one request; in random mode out_ready is re-rolled while waiting.
  // Directed callers may supply the expected word directly.
  task automatic send(input logic [2:0] o, input logic [4:0] t, input logic [4:0] n,
                      input logic [63:0] im, input bit rand_rdy,
                      input bit use_d, input bit d_ok, input logic [31:0] d_w,
                      output int waits);
    bit ok;
    logic [31:0] w;
    op = o; rt = t; rn = n; imm = im; in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
      waits++;
      #1;
    end
    if (!in_ready) begin
      flag("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    if (use_d) begin
      ok = d_ok; w = d_w;
    end else begin
      model(o, t, n, im, ok, w);
    end
    push_exp(ok, w);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    in_valid = 1'b0;
    q.delete();
    m_addr = 0;
    m_errc = 0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] gen_imm();
    logic [63:0] v;
    int k;
    int b;
    k = $urandom_range(0, 4);
    case (k)
      0: v = {$urandom, $urandom};
      1: v = 64'($urandom_range(0, 4200));
      2: begin
        b = (($urandom_range(0, 2) == 0) ? 8 : (($urandom_range(0, 1) == 0) ? 12 : 18));
        v = (64'd1 << b) + 64'($urandom_range(0, 4)) - 64'd2;
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      3: v = -64'($urandom_range(1, 300));
      default: v = -64'($urandom_range(1, 300000));
    endcase
    return v;
  endfunction

  // Monitor: compares every err pulse and every transferred word against the
  // head of the expectation queue, and checks the output holds while stalled.
  initial begin : monitor
    bit hold_v;
    logic [31:0] h_instr;
    logic [AW-1:0] h_addr;
    exp_t e;
    hold_v = 1'b0;
    h_instr = '0;
    h_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_instr", 64'(instr), 64'(h_instr));
          chk("hold_addr", 64'(addr), 64'(h_addr));
        end
        if (err) begin
          if (q.size() == 0 || !q[0].is_err) begin
            flag("err_unexpected");
          end else begin
            e = q.pop_front();
            chk("err_count", 64'(err_count), 64'(e.errc));
          end
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0 || q[0].is_err) begin
            flag("word_unexpected");
            if (q.size() != 0) void'(q.pop_front());
          end else begin
            e = q.pop_front();
            chk("word_instr", 64'(instr), 64'(e.instr));
            chk("word_addr", 64'(addr), 64'(e.addr));
          end
        end
        hold_v  = out_valid && !out_ready;
        h_instr = instr;
        h_addr  = addr;
      end
    end
  end

  initial begin : stim
    int w;
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; rt = '0; rn = '0; imm = '0;
    @(posedge clk); #1;
    do_reset(3);

    // LDUR with negative offset
    send(3'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 1, 32'hF85F8041, w);
    @(posedge clk); #1;
    do_reset(1);

    // ADDI then CBZ back-to-back, no bubble
    send(3'd3, 5'd3, 5'd4, 64'd5, 0, 1, 1, 32'h91001483, w);
    send(3'd2, 5'd0, 5'd0, '1, 0, 1, 1, 32'hB4FFFFE0, w);
    chk("b2b_no_wait", 64'(w), 64'd0);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    do_reset(1);

    // Two rejections, then the next legal word still gets addr 0
    send(3'd3, 5'd1, 5'd1, 64'd4096, 0, 1, 0, 32'h0, w);
    send(3'd6, 5'd1, 5'd1, 64'd0, 0, 1, 0, 32'h0, w);
    chk("rej_no_word", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("rej_err_count", 64'(err_count), 64'd2);
    chk("rej_still_empty", 64'(out_valid), 64'd0);
    send(3'd4, 5'd7, 5'd8, 64'd4095, 0, 0, 0, 32'h0, w);
    @(posedge clk); #1;

    // Stall with one word held while the next request waits
    out_ready = 1'b0;
    send(3'd1, 5'd9, 5'd10, 64'd255, 0, 0, 0, 32'h0, w);
    op = 3'd0; rt = 5'd11; rn = 5'd12; imm = -64'd256; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd0, 5'd11, 5'd12, -64'd256, 0, 0, 0, 32'h0, w);
    chk("release_no_wait", 64'(w), 64'd0);
    chk("release_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // Address wrap: 65 legal words
    do_reset(1);
    for (int i = 0; i < 65; i++) begin
      send(3'($urandom_range(0, 4)), 5'($urandom), 5'($urandom), 64'($urandom_range(0, 200)), 0, 0, 0, 32'h0, w);
    end
    @(posedge clk); #1;
    chk("wrap_addr_zero", 64'(addr), 64'd0);

    // Reset while a word is held and stalled
    out_ready = 1'b0;
    send(3'd2, 5'd5, 5'd0, 64'd100, 0, 0, 0, 32'h0, w);
    @(posedge clk); #1;
    chk("pre_rst_held", 64'(out_valid), 64'd1);
    do_reset(1);
    out_ready = 1'b1;
    send(3'd3, 5'd2, 5'd2, 64'd1, 0, 0, 0, 32'h0, w);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure (drives err_count to saturation)
    for (int i = 0; i < 450; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), gen_imm(), 1, 0, 0, 32'h0, w);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    chk("err_count_saturated", 64'(err_count), 64'(m_errc));

    // Drain everything still expected
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) flag("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 6, width of the emitted word-address counter (instruction memory depth 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 op  input  3  instruction select: 0 LDUR, 1 STUR, 2 CBZ, 3 ADDI, 4 SUBI; 5-7 illegal.
REQ-007 rt  input  5  Rt (LDUR/STUR/CBZ) or Rd (ADDI/SUBI).
REQ-008 rn  input  5  Rn (ignored for CBZ).
REQ-009 imm  input  64  immediate in the 64-bit form produced by the sign-extension decode stage.
REQ-010 out_valid  output  1  instr/addr hold an encoded word.
REQ-011 out_ready  input  1  downstream (instruction memory writer) accepts the word.
REQ-012 instr  output  32  encoded LEGv8 instruction.
REQ-013 addr  output  ADDR_W  word address for instr.
REQ-014 err  output  1  one-cycle pulse: request rejected.
REQ-015 err_count  output  8  saturating count of rejected requests.

Function
REQ-016 Handshake: request accepted when in_valid && in_ready; word transferred when out_valid && out_ready.
REQ-017 in_ready SHALL equal !reset && (!out_valid || out_ready) (single output register, drain and refill in the same cycle).
REQ-018 Latency: accepted legal request -> out_valid high with its instr/addr on the next cycle.
REQ-019 While out_valid && !out_ready, instr, addr and out_valid SHALL hold stable.
REQ-020 LDUR/STUR: instr = opcode[31:21] (LDUR 11111000010, STUR 11111000000), imm[8:0] at [20:12], 00 at [11:10], rn at [9:5], rt at [4:0].
REQ-021 CBZ: instr = 10110100 at [31:24], imm[18:0] at [23:5], rt at [4:0].
REQ-022 ADDI/SUBI: instr = opcode[31:22] (ADDI 1001000100, SUBI 1101000100), imm[11:0] at [21:10], rn at [9:5], rt at [4:0].
REQ-023 Range check: LDUR/STUR legal iff imm[63:8] all equal (9-bit signed); CBZ legal iff imm[63:18] all equal (19-bit signed); ADDI/SUBI legal iff imm[63:12] == 0 (12-bit unsigned).
REQ-024 Accepted request with illegal op or out-of-range imm: no word emitted, err pulses high exactly one cycle after acceptance, err_count increments unless at 255, addr unchanged.
REQ-025 A rejected request SHALL NOT disturb a word already held in the output register.
REQ-026 Address counter: each legal accepted request takes the current counter value as addr, then counter increments by 1, wrapping 2^ADDR_W-1 -> 0.
REQ-027 Simultaneous drain and accept of a legal request: out_valid stays high, new instr/addr appear next cycle, no bubble.
REQ-028 Simultaneous drain and accept of an illegal request: out_valid falls next cycle, err pulses.

Reset
REQ-029 While reset is high at a clock edge: out_valid=0, instr=0, addr counter=0, err=0, err_count=0; in_ready=0 while reset is asserted.
REQ-030 Reset asserted mid-transfer SHALL discard the held word; the first word after reset uses addr 0.

Verification
REQ-031 LDUR rt=1 rn=2 imm=0xFFFF_FFFF_FFFF_FFF8, out_ready=1 -> next cycle instr=0xF85F8041, addr=0.
REQ-032 ADDI rt=3 rn=4 imm=5 then CBZ rt=0 imm=all-ones back-to-back -> instr 0x91001483 (addr 0), then 0xB4FFFFE0 (addr 1), no bubble.
REQ-033 ADDI imm=4096, and op=6 -> err one-cycle pulse each, err_count=2, out_valid stays 0, next legal word gets addr 0.
REQ-034 out_ready=0 with one word held, in_valid high -> in_ready=0, instr/addr stable for 5 cycles; release out_ready -> second word appears the following cycle.
REQ-035 ADDR_W=6, 64 legal requests then one more -> addr runs 0..63, 65th word addr=0.
REQ-036 Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0, err_count=0 after the edge; next word addr=0.
